imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the byte-addressed, little-endian instruction memory from an 8-bit valid/ready byte stream (UART or debug bridge side). It is the writer for the same byte array the fetch path reads. It holds the core in reset-fetch (`cpu_hold`) until a complete, checksum-verified image has been written. It sits between the external byte source, the instruction memory write port, and the PC/fetch stall input.

## Interface
- `DEPTH_BYTES`, default 80: instruction memory size in bytes. Images larger than this are rejected.
- `ADDR_W`, default 64: width of the memory write address, matching the fetch address width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a new load.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `mem_wr_en`  out  1  byte write strobe to instruction memory.
- `mem_wr_addr`  out  ADDR_W  byte address.
- `mem_wr_data`  out  8  byte to write.
- `cpu_hold`  out  1  holds the PC at 0 and suppresses fetch while high.
- `done`  out  1  image loaded and verified.
- `err_code`  out  2  00 none, 01 checksum mismatch, 10 image too large.
- `words_loaded`  out  16  count of complete 32-bit words written.

## Operation
- Image format, in order:
  - N, the word count, as 16 bits little-endian (2 bytes).
  - 4·N payload bytes, least significant byte of each instruction first.
  - 1 checksum byte equal to the XOR of every preceding byte, header included.
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - IDLE → LEN0 on `start`.
  - LEN0 → LEN1 on handshake.
  - LEN1 → DATA on handshake.
  - LEN1 → CSUM on handshake when N = 0.
  - LEN1 → ERR(10) on handshake when 4·N > `DEPTH_BYTES`.
  - DATA → CSUM on handshake of payload byte 4·N−1.
  - CSUM → DONE when the received byte equals the running XOR; otherwise CSUM → ERR(01).
  - DONE or ERR → LEN0 on `start`: a reload. This clears `done`, `err_code`, `words_loaded`, the XOR accumulator and the address counter.
- `start` in LEN0, LEN1, DATA or CSUM is ignored.
- Handshake means `rx_valid & rx_ready` at a rising edge.
- `rx_ready` is 1 exactly in LEN0, LEN1, DATA and CSUM. It is 0 in IDLE, DONE and ERR, and bytes presented there are not consumed.
- Payload bytes are written to consecutive addresses starting at 0. The byte count is 16+2 bits wide, and `mem_wr_addr` is that count zero-extended to ADDR_W. The address never wraps: the overflow check guarantees the last address is ≤ `DEPTH_BYTES`−1.
- `words_loaded` increments when the byte at address offset 3 mod 4 is written.
- `cpu_hold` is 1 in every state except DONE. An error therefore leaves the core held.
- Reset (any time, including mid-DATA) aborts immediately with no further writes and enters IDLE. Memory contents already written are left untouched.
- Reset values: `rx_ready`=0, `mem_wr_en`=0, `mem_wr_addr`=0, `mem_wr_data`=0, `cpu_hold`=1, `done`=0, `err_code`=00, `words_loaded`=0.

## Timing
- Throughput: one byte per cycle when `rx_valid` is held high. Gaps in `rx_valid` stall with no side effects.
- Write latency: a payload handshake in cycle t produces `mem_wr_en`=1 with the matching address and data in cycle t+1, for exactly one cycle. The memory commits on the edge ending t+1.
- `done` and `cpu_hold`=0 are first visible in cycle t+1 after the CSUM handshake in cycle t. The last payload write has already committed by then.
- `err_code` is visible in cycle t+1 after the offending handshake in cycle t. `rx_ready` is 0 from that cycle onward.
- All outputs are registered; there are no combinational paths from `rx_*` to any output.

## Structure
- Package `imem_loader_pkg`:
  - State enum.
  - Error-code constants ERR_NONE, ERR_CSUM, ERR_SIZE.
  - HDR_BYTES = 2.
- Flat module, no sub-modules. The XOR accumulator, byte counter and FSM are small enough to share one file.

## Test plan
- Two-word load: `start`, then 02 00 93 05 80 00 63 84 B6 04 41 → addresses 0–7 receive 93 05 80 00 63 84 B6 04; `words_loaded`=2; `done`=1 and `cpu_hold`=0 the cycle after 41.
- Same stream with checksum 40 → `err_code`=01, `done`=0, `cpu_hold`=1, `rx_ready`=0. A subsequent `start` plus the correct stream ends in DONE.
- Oversize header 15 00 (N=21, 84 bytes > 80) → `err_code`=10 the cycle after the second byte; zero `mem_wr_en` pulses; following bytes not consumed.
- Empty image 00 00 00 → DONE, no writes, `words_loaded`=0.
- `rx_valid` toggled randomly during the two-word load → identical write sequence. Each write appears exactly one cycle after its handshake.
- Reset asserted after 3 payload bytes → all outputs return to reset values asynchronously; no 4th write. `start` mid-DATA has no effect.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared types and constants for the boot-time instruction memory loader.
//   - state_e    : loader FSM states
//   - ERR_*      : values driven on err_code
//   - HDR_BYTES  : length of the little-endian word-count header
//   - CNT_W      : width of the payload byte counter (16-bit word count * 4)
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_SIZE = 2'b10;

  localparam int HDR_BYTES = 2;
  localparam int CNT_W     = 18;

endpackage

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader. Consumes an 8-bit valid/ready byte stream
//   carrying [N lo, N hi, 4*N payload bytes, XOR checksum], writes the
//   payload to instruction memory at byte addresses 0.., and keeps the core
//   held until a verified image is in place.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   start        : one-cycle pulse, begins a load from IDLE/DONE/ERR
//   rx_data      : stream byte
//   rx_valid     : rx_data valid
//   rx_ready     : loader accepts a byte this cycle (registered)
//   mem_wr_en    : one-cycle byte write strobe
//   mem_wr_addr  : byte address (payload count, zero-extended)
//   mem_wr_data  : byte to write
//   cpu_hold     : holds the PC at 0 / suppresses fetch; low only in DONE
//   done         : image loaded and checksum verified
//   err_code     : 00 none, 01 checksum mismatch, 10 image too large
//   words_loaded : number of complete 32-bit words written
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// LEN0  | waiting for word-count low byte
// LEN1  | waiting for word-count high byte, size check on handshake
// DATA  | writing payload bytes to memory
// CSUM  | waiting for checksum byte
// DONE  | image verified, core released
// ERR   | load failed (err_code set), core stays held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_BYTES = 80,
  parameter int ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [15:0]       words_loaded
);

  localparam logic [CNT_W-1:0] DEPTH_LIM = CNT_W'(DEPTH_BYTES);

  state_e             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         xor_q, xor_d;
  logic               rdy_q, rdy_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic [15:0]        words_q, words_d;

  logic               hs;
  logic [15:0]        n_full;
  logic [CNT_W-1:0]   img_bytes;
  logic               last_payload;

  // rdy_q is registered from the next state, so it is exactly the
  // "state is LEN0..CSUM" flag without any path from rx_* to rx_ready.
  assign hs           = rx_valid & rdy_q;
  assign n_full       = {rx_data, len_q[7:0]};
  assign img_bytes    = {n_full, 2'b00};
  assign last_payload = (cnt_q == ({len_q, 2'b00} - CNT_W'(1)));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    xor_d     = xor_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    words_d   = words_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN0;
          len_d   = '0;
          cnt_d   = '0;
          xor_d   = '0;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = ERR_NONE;
          words_d = '0;
        end
      end
      ST_LEN0: begin
        if (hs) begin
          len_d[7:0] = rx_data;
          xor_d      = xor_q ^ rx_data;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (hs) begin
          len_d[15:8] = rx_data;
          xor_d       = xor_q ^ rx_data;
          if (n_full == 16'd0) begin
            state_d = ST_CSUM;
          end else if (img_bytes > DEPTH_LIM) begin
            state_d = ST_ERR;
            err_d   = ERR_SIZE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'(cnt_q);
          wr_data_d = rx_data;
          cnt_d     = cnt_q + CNT_W'(1);
          xor_d     = xor_q ^ rx_data;
          if (cnt_q[1:0] == 2'd3) begin
            words_d = words_q + 16'd1;
          end
          if (last_payload) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (hs) begin
          if (rx_data == xor_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = ERR_CSUM;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rdy_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
            (state_d == ST_DATA) || (state_d == ST_CSUM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      xor_q     <= '0;
      rdy_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= ERR_NONE;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      xor_q     <= xor_d;
      rdy_q     <= rdy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
      words_q   <= words_d;
    end
  end

  assign rx_ready     = rdy_q;
  assign mem_wr_en    = wr_en_q;
  assign mem_wr_addr  = wr_addr_q;
  assign mem_wr_data  = wr_data_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err_code     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed bench for imem_loader. A byte-position model of the image
//   format predicts every output each cycle; a write log plus literal
//   expectations pin the model to hand-computed values.
module tb_imem_loader;

  localparam int DEPTH  = 80;
  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [7:0]        mem_wr_data;
  logic              cpu_hold;
  logic              done;
  logic [1:0]        err_code;
  logic [15:0]       words_loaded;

  imem_loader #(.DEPTH_BYTES(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int vecs  = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: phase 0 idle, 1 loading, 2 done, 3 error
  int         m_phase = 0;
  int         m_pos   = 0;
  int         m_n     = 0;
  int         m_words = 0;
  logic [7:0] m_xor   = 8'h00;
  logic [1:0] m_err   = 2'b00;
  bit         m_wr    = 1'b0;
  int         m_waddr = 0;
  logic [7:0] m_wdata = 8'h00;
  logic [7:0] m_b;

  int         wr_count = 0;
  int         wlog_addr[$];
  logic [7:0] wlog_data[$];

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_pos = 0; m_n = 0; m_words = 0;
      m_xor = 8'h00; m_err = 2'b00; m_wr = 1'b0;
    end else begin
      check("rx_ready",     64'(rx_ready),     64'(m_phase == 1));
      check("cpu_hold",     64'(cpu_hold),     64'(m_phase != 2));
      check("done",         64'(done),         64'(m_phase == 2));
      check("err_code",     64'(err_code),     64'(m_err));
      check("words_loaded", 64'(words_loaded), 64'(m_words));
      check("mem_wr_en",    64'(mem_wr_en),    64'(m_wr));
      if (m_wr) begin
        check("mem_wr_addr", 64'(mem_wr_addr), 64'(m_waddr));
        check("mem_wr_data", 64'(mem_wr_data), 64'(m_wdata));
      end
      if (mem_wr_en) begin
        wr_count++;
        wlog_addr.push_back(int'(mem_wr_addr));
        wlog_data.push_back(mem_wr_data);
      end

      // advance with the inputs that the coming edge will sample
      m_wr = 1'b0;
      if (start && m_phase != 1) begin
        m_phase = 1; m_pos = 0; m_n = 0; m_words = 0;
        m_xor = 8'h00; m_err = 2'b00;
      end else if (m_phase == 1 && rx_valid) begin
        m_b = rx_data;
        if (m_pos < 2) begin
          m_xor = m_xor ^ m_b;
          if (m_pos == 0) begin
            m_n = int'(m_b);
          end else begin
            m_n = m_n + int'(m_b) * 256;
            if (4 * m_n > DEPTH) begin
              m_phase = 3;
              m_err   = 2'b10;
            end
          end
          m_pos++;
        end else if (m_pos < 2 + 4 * m_n) begin
          m_wr    = 1'b1;
          m_waddr = m_pos - 2;
          m_wdata = m_b;
          m_xor   = m_xor ^ m_b;
          if ((m_pos - 2) % 4 == 3) m_words++;
          m_pos++;
        end else begin
          if (m_b == m_xor) begin
            m_phase = 2;
          end else begin
            m_phase = 3;
            m_err   = 2'b01;
          end
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 20) check("send_timeout_rx_ready", 64'(rx_ready), 64'(1));
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input bit gaps);
    foreach (q[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      send_byte(q[i]);
    end
  endtask

  task automatic check_two_word_log(input string tag, input int base);
    logic [7:0] exp_pl[$];
    exp_pl = '{8'h93, 8'h05, 8'h80, 8'h00, 8'h63, 8'h84, 8'hB6, 8'h04};
    check({tag, "_nwrites"}, 64'(wr_count - base), 64'(8));
    if (wr_count - base == 8) begin
      for (int i = 0; i < 8; i++) begin
        check({tag, "_addr"}, 64'(wlog_addr[base + i]), 64'(i));
        check({tag, "_data"}, 64'(wlog_data[base + i]), 64'(exp_pl[i]));
      end
    end
  endtask

  logic [7:0] s_good[$] = '{8'h02, 8'h00, 8'h93, 8'h05, 8'h80, 8'h00,
                            8'h63, 8'h84, 8'hB6, 8'h04, 8'h41};
  logic [7:0] s_bad[$]  = '{8'h02, 8'h00, 8'h93, 8'h05, 8'h80, 8'h00,
                            8'h63, 8'h84, 8'hB6, 8'h04, 8'h40};
  logic [7:0] s_big[$]  = '{8'h15, 8'h00};
  logic [7:0] s_empty[$] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] s_part[$] = '{8'h02, 8'h00, 8'h93, 8'h05, 8'h80};

  initial begin
    int base;

    // reset values while reset is held
    repeat (2) @(posedge clk);
    #3;
    check("rst_rx_ready",     64'(rx_ready),     64'(0));
    check("rst_mem_wr_en",    64'(mem_wr_en),    64'(0));
    check("rst_mem_wr_addr",  64'(mem_wr_addr),  64'(0));
    check("rst_mem_wr_data",  64'(mem_wr_data),  64'(0));
    check("rst_cpu_hold",     64'(cpu_hold),     64'(1));
    check("rst_done",         64'(done),         64'(0));
    check("rst_err_code",     64'(err_code),     64'(0));
    check("rst_words_loaded", 64'(words_loaded), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    // two-word load
    base = wr_count;
    pulse_start();
    send_bytes(s_good, 1'b0);
    check("t1_done",  64'(done),         64'(1));
    check("t1_hold",  64'(cpu_hold),     64'(0));
    check("t1_words", 64'(words_loaded), 64'(2));
    check_two_word_log("t1", base);

    // bad checksum, then a good reload
    pulse_start();
    send_bytes(s_bad, 1'b0);
    check("t2_err",   64'(err_code), 64'(1));
    check("t2_done",  64'(done),     64'(0));
    check("t2_hold",  64'(cpu_hold), 64'(1));
    check("t2_ready", 64'(rx_ready), 64'(0));
    pulse_start();
    send_bytes(s_good, 1'b0);
    check("t2_reload_done", 64'(done), 64'(1));

    // oversize header
    base = wr_count;
    pulse_start();
    send_bytes(s_big, 1'b0);
    check("t3_err",   64'(err_code), 64'(2));
    check("t3_ready", 64'(rx_ready), 64'(0));
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    repeat (4) @(posedge clk); #1;
    rx_valid = 1'b0;
    check("t3_err_hold", 64'(err_code),       64'(2));
    check("t3_nwrites",  64'(wr_count - base), 64'(0));

    // empty image
    base = wr_count;
    pulse_start();
    send_bytes(s_empty, 1'b0);
    check("t4_done",    64'(done),            64'(1));
    check("t4_words",   64'(words_loaded),    64'(0));
    check("t4_nwrites", 64'(wr_count - base), 64'(0));

    // two-word load with random rx_valid gaps
    base = wr_count;
    pulse_start();
    send_bytes(s_good, 1'b1);
    check("t5_done",  64'(done),         64'(1));
    check("t5_words", 64'(words_loaded), 64'(2));
    check_two_word_log("t5", base);

    // start mid-DATA ignored, then async reset after 3 payload bytes
    pulse_start();
    send_bytes(s_part, 1'b0);
    pulse_start();
    check("t6_ready_after_start", 64'(rx_ready), 64'(1));
    check("t6_hold_after_start",  64'(cpu_hold), 64'(1));
    base = wr_count;
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("t6_rx_ready",    64'(rx_ready),     64'(0));
    check("t6_mem_wr_en",   64'(mem_wr_en),    64'(0));
    check("t6_mem_wr_addr", 64'(mem_wr_addr),  64'(0));
    check("t6_mem_wr_data", 64'(mem_wr_data),  64'(0));
    check("t6_cpu_hold",    64'(cpu_hold),     64'(1));
    check("t6_done",        64'(done),         64'(0));
    check("t6_err_code",    64'(err_code),     64'(0));
    check("t6_words",       64'(words_loaded), 64'(0));
    repeat (3) @(posedge clk); #1;
    check("t6_nwrites", 64'(wr_count - base), 64'(0));
    rx_valid = 1'b0;
    reset    = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("t6_idle_ready", 64'(rx_ready), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
